// File: rtl/bs_mac_scheduler.sv
// rtl/bs_mac_scheduler.sv - operand sequencer for one bit-serial FP16 x INTn multiplier lane
module bs_mac_scheduler #(
    parameter int ACT_WIDTH    = 16,
    parameter int MAX_PREC     = 8,
    parameter int LEN_WIDTH    = 10,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           cfg_precision,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 start,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [MAX_PREC-1:0]  in_w,
    output logic                 pe_valid,
    output logic [ACT_WIDTH-1:0] pe_act,
    output logic                 pe_w,
    output logic [3:0]           pe_precision,
    output logic                 pe_last,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [LEN_WIDTH-1:0] elem_cnt
);

    localparam int         BW       = (MAX_PREC > 1) ? $clog2(MAX_PREC) : 1;
    localparam int         DW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [3:0] PREC_MAX = 4'(MAX_PREC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [ACT_WIDTH-1:0] r_act;
    logic [MAX_PREC-1:0]  r_w;
    logic [BW-1:0]        r_bit;
    logic [3:0]           r_prec;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_elem;
    logic [DW-1:0]        r_drain;
    logic                 r_cfg_err;

    logic                 w_cfg_ok;
    logic                 w_last_elem;
    logic                 w_elem_end;
    logic                 w_in_ready;
    logic                 w_take;
    logic [BW-1:0]        w_bit_init;

    assign w_cfg_ok    = (cfg_precision >= 4'd2) && (cfg_precision <= PREC_MAX) && (cfg_len != '0);
    assign w_last_elem = (r_elem == (r_len - LEN_WIDTH'(1)));
    assign w_elem_end  = (r_state == S_SHIFT) && (r_bit == '0);
    // Ready in FETCH, or on the final bit of a non-last element so the next
    // pair can follow without a bubble; an abort in the same cycle withdraws it.
    assign w_in_ready  = !clr && ((r_state == S_FETCH) || (w_elem_end && !w_last_elem));
    assign w_take      = w_in_ready && in_valid;
    // Weight is shifted MSB-first, starting at the latched precision's top bit.
    assign w_bit_init  = BW'(r_prec - 4'd1);

    assign in_ready     = w_in_ready;
    assign pe_valid     = (r_state == S_SHIFT);
    assign pe_act       = r_act;
    assign pe_w         = r_w[r_bit];
    assign pe_precision = r_prec;
    assign pe_last      = (r_state == S_SHIFT) && w_last_elem;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign cfg_err      = r_cfg_err;
    assign elem_cnt     = r_elem;

    // Job sequencing: config latch, operand capture, bit shifting, drain and completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_act     <= '0;
            r_w       <= '0;
            r_bit     <= '0;
            r_prec    <= '0;
            r_len     <= '0;
            r_elem    <= '0;
            r_drain   <= '0;
            r_cfg_err <= 1'b0;
        end else if (clr) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_prec    <= cfg_precision;
                            r_len     <= cfg_len;
                            r_elem    <= '0;
                            r_cfg_err <= 1'b0;
                            r_state   <= S_FETCH;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_take) begin
                        r_act   <= in_act;
                        r_w     <= in_w;
                        r_bit   <= w_bit_init;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_bit != '0) begin
                        r_bit <= r_bit - BW'(1);
                    end else begin
                        r_elem <= r_elem + LEN_WIDTH'(1);
                        if (w_last_elem) begin
                            r_drain <= DW'(DRAIN_CYCLES - 1);
                            r_state <= S_DRAIN;
                        end else if (w_take) begin
                            r_act <= in_act;
                            r_w   <= in_w;
                            r_bit <= w_bit_init;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain - DW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_mac_scheduler.sv
// tb/tb_bs_mac_scheduler.sv - scoreboard bench for bs_mac_scheduler
module tb_bs_mac_scheduler;

    localparam int AW = 16;
    localparam int MP = 8;
    localparam int LW = 10;
    localparam int DC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    cfg_precision = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_act = '0;
    logic [MP-1:0] in_w = '0;
    logic          pe_valid;
    logic [AW-1:0] pe_act;
    logic          pe_w;
    logic [3:0]    pe_precision;
    logic          pe_last;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [LW-1:0] elem_cnt;

    bs_mac_scheduler #(.ACT_WIDTH(AW), .MAX_PREC(MP), .LEN_WIDTH(LW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .cfg_precision(cfg_precision), .cfg_len(cfg_len),
        .start(start), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_w(in_w), .pe_valid(pe_valid), .pe_act(pe_act),
        .pe_w(pe_w), .pe_precision(pe_precision), .pe_last(pe_last), .busy(busy),
        .done(done), .cfg_err(cfg_err), .elem_cnt(elem_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] act;
        logic          w;
        logic          last;
        logic          endf;
        logic [3:0]    prec;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] acts[$];
    logic [MP-1:0] ws[$];
    int            stalls[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            g_abort = 0;
    int            g_lowbusy = 0;
    int            g_dones = 0;
    logic          prev_valid = 1'b0;
    logic          prev_end = 1'b0;
    exp_t          m_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected lane beat whenever the lane is driven
    always @(negedge clk) begin
        if (done) g_dones++;
        if (busy && !pe_valid) g_lowbusy++;
        if (pe_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pe_valid", 32'(pe_valid), 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("pe_act", 32'(pe_act), 32'(m_e.act));
                check("pe_w", 32'(pe_w), 32'(m_e.w));
                check("pe_last", 32'(pe_last), 32'(m_e.last));
                check("pe_precision", 32'(pe_precision), 32'(m_e.prec));
                prev_end = m_e.endf;
            end
        end else if (prev_valid && g_abort == 0) begin
            check("valid_drop_at_boundary", 32'(prev_end), 32'd1);
        end
        prev_valid = pe_valid;
    end

    task automatic fill_job(input int len, input int max_stall);
        acts.delete(); ws.delete(); stalls.delete();
        for (int i = 0; i < len; i++) begin
            acts.push_back(AW'($urandom));
            ws.push_back(MP'($urandom));
            stalls.push_back($urandom_range(max_stall, 0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pe_valid"}, 32'(pe_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pe_last"}, 32'(pe_last), 32'd0);
        check({tag, "_pe_w"}, 32'(pe_w), 32'd0);
        check({tag, "_pe_act"}, 32'(pe_act), 32'd0);
        check({tag, "_pe_precision"}, 32'(pe_precision), 32'd0);
        check({tag, "_elem_cnt"}, 32'(elem_cnt), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    // abort_kind: 0 none, 1 clr, 2 reset; abort fires on lane beat number abort_bits
    task automatic run_job(input int prec, input int len, input int abort_kind, input int abort_bits);
        int   k, elem, stall_left, total_stall, vcount, dcyc, start_dones;
        exp_t e;
        elem = 0; total_stall = 0; vcount = 0; dcyc = -1;
        stall_left = stalls[0];
        @(negedge clk);
        cfg_precision = 4'(prec); cfg_len = LW'(len); start = 1'b1;
        g_lowbusy = 0; start_dones = g_dones;
        k = 0;
        while (1) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            cfg_precision = 4'($urandom);
            cfg_len = LW'($urandom);
            if (k == 1) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("cfg_err_cleared", 32'(cfg_err), 32'd0);
            end
            if (done) begin
                dcyc = k;
                break;
            end
            if (pe_valid) vcount++;
            if (abort_kind != 0 && vcount == abort_bits) begin
                g_abort = 1;
                in_valid = 1'b0;
                if (abort_kind == 1) begin
                    clr = 1'b1;
                    @(posedge clk);
                    #1;
                    clr = 1'b0;
                    check("clr_pe_valid", 32'(pe_valid), 32'd0);
                    check("clr_busy", 32'(busy), 32'd0);
                    check("clr_in_ready", 32'(in_ready), 32'd0);
                    check("clr_elem_cnt", 32'(elem_cnt), 32'((abort_bits - 1) / prec));
                    check("clr_sb_left", 32'(sb.size()), 32'(elem * prec - abort_bits));
                    sb.delete();
                    repeat (20) @(negedge clk);
                    check("clr_no_done", 32'(g_dones - start_dones), 32'd0);
                    check("clr_stays_idle", 32'(busy), 32'd0);
                end else begin
                    #2;
                    rst = 1'b0;
                    #1;
                    check_all_zero("async_rst");
                    sb.delete();
                    @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                end
                g_abort = 0;
                return;
            end
            if (in_ready) begin
                if (stall_left > 0) begin
                    in_valid = 1'b0;
                    stall_left--;
                    total_stall++;
                end else if (elem < len) begin
                    in_valid = 1'b1;
                    in_act = acts[elem];
                    in_w = ws[elem];
                    for (int i = prec - 1; i >= 0; i--) begin
                        e.act = acts[elem];
                        e.w = ws[elem][i];
                        e.last = (elem == len - 1);
                        e.endf = (i == 0);
                        e.prec = 4'(prec);
                        sb.push_back(e);
                    end
                    elem++;
                    stall_left = (elem < len) ? stalls[elem] : 0;
                end
            end else begin
                in_valid = 1'($urandom);
                in_act = AW'($urandom);
                in_w = MP'($urandom);
            end
            if (k > 5000) begin
                check("done_timeout", 32'(done), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        check("done_cycle", 32'(dcyc), 32'(len * prec + total_stall + DC + 2));
        check("elem_cnt_final", 32'(elem_cnt), 32'(len));
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("valid_low_cycles", 32'(g_lowbusy), 32'(total_stall + DC + 2));
        check("done_count", 32'(g_dones - start_dones), 32'd1);
    endtask

    task automatic bad_start(input int prec, input int len);
        @(negedge clk);
        cfg_precision = 4'(prec); cfg_len = LW'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bad_cfg_err", 32'(cfg_err), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bad_still_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        #20;
        @(negedge clk);
        rst = 1'b1;

        fill_job(3, 0);
        ws[0] = 8'h0B; ws[1] = 8'h05; ws[2] = 8'h0F;
        run_job(4, 3, 0, 0);

        fill_job(2, 0);
        stalls[1] = 3;
        run_job(8, 2, 0, 0);

        bad_start(1, 3);
        bad_start(4, 0);
        bad_start(9, 2);
        fill_job(2, 1);
        run_job(3, 2, 0, 0);

        fill_job(4, 0);
        run_job(4, 4, 1, 6);
        fill_job(4, 0);
        run_job(4, 4, 0, 0);

        fill_job(2, 0);
        run_job(8, 2, 2, 5);
        fill_job(3, 2);
        run_job(5, 3, 0, 0);

        fill_job(1, 0);
        ws[0] = 8'hFE;
        run_job(2, 1, 0, 0);

        for (int j = 0; j < 10; j++) begin
            fill_job($urandom_range(6, 1), 3);
            run_job($urandom_range(MP, 2), acts.size(), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
